// File: rtl/tcp_tx_arbiter.sv
// Round-robin, packet-granular share of one TCP tx path among NUM_REQ lanes.
// Define TX_ARB_STATS_EN to enable per-lane packet/byte counters.
module tcp_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int STS_FIFO_DEPTH = 32,
  parameter int DATA_WIDTH     = 512
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [NUM_REQ-1:0]              s_meta_valid,
  output logic [NUM_REQ-1:0]              s_meta_ready,
  input  logic [NUM_REQ*32-1:0]           s_meta_data,
  input  logic [NUM_REQ-1:0]              s_data_valid,
  output logic [NUM_REQ-1:0]              s_data_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_data_data,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] s_data_keep,
  input  logic [NUM_REQ-1:0]              s_data_last,
  output logic                            m_meta_valid,
  input  logic                            m_meta_ready,
  output logic [31:0]                     m_meta_data,
  output logic                            m_data_valid,
  input  logic                            m_data_ready,
  output logic [DATA_WIDTH-1:0]           m_data_data,
  output logic [DATA_WIDTH/8-1:0]         m_data_keep,
  output logic                            m_data_last,
  input  logic                            s_sts_valid,
  output logic                            s_sts_ready,
  input  logic [63:0]                     s_sts_data,
  output logic [NUM_REQ-1:0]              m_sts_valid,
  input  logic [NUM_REQ-1:0]              m_sts_ready,
  output logic [NUM_REQ*64-1:0]           m_sts_data,
  output logic [NUM_REQ*32-1:0]           stat_pkt_cnt,
  output logic [NUM_REQ*48-1:0]           stat_byte_cnt
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int KW = DATA_WIDTH / 8;
  localparam int AW = $clog2(STS_FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_META,
    S_DATA
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_grant;
  logic [IW-1:0] r_last;
  logic [IW-1:0] r_fifo [STS_FIFO_DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;

  logic [31:0]         w_meta_lane [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_dat_lane [NUM_REQ];
  logic [KW-1:0]       w_keep_lane [NUM_REQ];

  logic [31:0]   w_sel_meta;
  logic [15:0]   w_len;
  logic          w_sel_last;
  logic [IW-1:0] w_pick;
  logic          w_found;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_dlast;
  logic [IW-1:0] w_head;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign w_meta_lane[g] = s_meta_data[32*g +: 32];
    assign w_dat_lane[g]  = s_data_data[DATA_WIDTH*g +: DATA_WIDTH];
    assign w_keep_lane[g] = s_data_keep[KW*g +: KW];
    assign m_sts_data[64*g +: 64] = s_sts_data;
  end

  assign w_sel_meta = w_meta_lane[r_grant];
  assign w_len      = w_sel_meta[31:16];
  assign w_sel_last = s_data_last[r_grant];
  assign w_full     = (r_cnt == CW'(STS_FIFO_DEPTH));
  assign w_empty    = (r_cnt == '0);
  assign w_head     = r_fifo[r_rd];

  // Search starts just after the last completed grant.
  always_comb begin
    int j;
    w_pick  = r_last;
    w_found = 1'b0;
    j       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = (int'(r_last) + i) % NUM_REQ;
      if (!w_found && s_meta_valid[j]) begin
        w_pick  = IW'(j);
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    m_meta_valid = 1'b0;
    s_meta_ready = '0;
    m_data_valid = 1'b0;
    s_data_ready = '0;
    m_meta_data  = w_sel_meta;
    m_data_data  = w_dat_lane[r_grant];
    m_data_keep  = w_keep_lane[r_grant];
    m_data_last  = w_sel_last;
    unique case (r_state)
      S_META: begin
        m_meta_valid          = s_meta_valid[r_grant] & ~w_full;
        s_meta_ready[r_grant] = m_meta_ready & ~w_full;
      end
      S_DATA: begin
        m_data_valid          = s_data_valid[r_grant];
        s_data_ready[r_grant] = m_data_ready;
      end
      default: ;
    endcase
  end

  assign w_push  = m_meta_valid & m_meta_ready;
  assign w_dlast = m_data_valid & m_data_ready & w_sel_last;

  always_comb begin
    m_sts_valid         = '0;
    m_sts_valid[w_head] = s_sts_valid & ~w_empty;
    s_sts_ready         = m_sts_ready[w_head] & ~w_empty;
  end

  assign w_pop = s_sts_valid & s_sts_ready;

  // Zero-length packets also close their grant so a lone lane cannot hog.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_last  <= IW'(NUM_REQ - 1);
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_state <= S_META;
          end
        end
        S_META: begin
          if (w_push) begin
            if (w_len == '0) begin
              r_last  <= r_grant;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_dlast) begin
            r_last  <= r_grant;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (w_push)
      r_fifo[r_wr] <= r_grant;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push)
        r_wr <= r_wr + AW'(1);
      if (w_pop)
        r_rd <= r_rd + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

`ifdef TX_ARB_STATS_EN
  logic [31:0] r_pkt  [NUM_REQ];
  logic [47:0] r_byte [NUM_REQ];

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_pkt[i]  <= '0;
        r_byte[i] <= '0;
      end
    end else if (w_push) begin
      r_pkt[r_grant]  <= r_pkt[r_grant] + 32'd1;
      r_byte[r_grant] <= r_byte[r_grant] + 48'(w_len);
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_pkt_cnt[32*g +: 32]  = r_pkt[g];
    assign stat_byte_cnt[48*g +: 48] = r_byte[g];
  end
`else
  assign stat_pkt_cnt  = '0;
  assign stat_byte_cnt = '0;
`endif

endmodule
